// File: rtl/mult_accumulator.sv
// Accumulates N_TERMS unsigned products per batch and hands the sum downstream over valid/ready.
// Optional macro MAC_SATURATE_EN: clamp acc_out to all-ones on carry instead of wrapping.
module mult_accumulator #(
    parameter int PW      = 8,
    parameter int ACC_W   = 10,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [PW-1:0]    p_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [7:0]       term_cnt
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_overflow;
    logic [7:0]         r_cnt;

`ifdef MAC_SATURATE_EN
    // Once a batch has carried, it stays pinned at full scale until the handoff.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] sum, input logic sticky);
        return (sum[ACC_W] || sticky) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction
`endif

    assign w_accept = in_valid && (r_state == ACCUM) && !clear;
    assign w_last   = (r_cnt == 8'(N_TERMS - 1));
    assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(p_in);

`ifdef MAC_SATURATE_EN
    assign w_acc_next = sat_acc(w_sum, r_overflow);
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last) w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next_state = ACCUM;
            end
            default: w_next_state = ACCUM;
        endcase
        if (clear) w_next_state = ACCUM;
    end

    // Handoff clears the accumulator so the next batch starts from zero one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else if (clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else if (r_state == DONE && out_ready) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_overflow <= r_overflow | w_sum[ACC_W];
            r_cnt      <= w_last ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign acc_out   = r_acc;
    assign overflow  = r_overflow;
    assign term_cnt  = r_cnt;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: a 4-term instance and a 5-term instance for overflow.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_clear, a_valid, a_rdy, a_ov, a_or, a_ovf;
    logic [7:0] a_p, a_cnt;
    logic [9:0] a_acc;
    logic       b_clear, b_valid, b_rdy, b_ov, b_or, b_ovf;
    logic [7:0] b_p, b_cnt;
    logic [9:0] b_acc;

    logic [10:0] q4[$];
    logic [10:0] q5[$];
    logic [10:0] e4, e5;
    int n_pass = 0, n_total = 0;
    int m_pass = 0, m_total = 0;
    bit m_stop = 1'b0;

    always #5 clk = ~clk;

    mult_accumulator #(.PW(8), .ACC_W(10), .N_TERMS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .p_in(a_p), .in_valid(a_valid),
        .in_ready(a_rdy), .acc_out(a_acc), .out_valid(a_ov), .out_ready(a_or),
        .overflow(a_ovf), .term_cnt(a_cnt)
    );

    mult_accumulator #(.PW(8), .ACC_W(10), .N_TERMS(5)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .p_in(b_p), .in_valid(b_valid),
        .in_ready(b_rdy), .acc_out(b_acc), .out_valid(b_ov), .out_ready(b_or),
        .overflow(b_ovf), .term_cnt(b_cnt)
    );

    // Monitor: pops an expected {overflow, acc} on every output handshake.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_or) begin
            m_total++;
            if (q4.size() == 0) begin
                $display("FAIL a_unexpected_out: got acc=%0d ovf=%0d, required no output", a_acc, a_ovf);
                m_stop = 1'b1;
            end else begin
                e4 = q4.pop_front();
                if ({a_ovf, a_acc} == e4) m_pass++;
                else begin
                    $display("FAIL a_result: got acc=%0d ovf=%0d, required acc=%0d ovf=%0d",
                             a_acc, a_ovf, e4[9:0], e4[10]);
                    m_stop = 1'b1;
                end
            end
        end
        if (rst_n && b_ov && b_or) begin
            m_total++;
            if (q5.size() == 0) begin
                $display("FAIL b_unexpected_out: got acc=%0d ovf=%0d, required no output", b_acc, b_ovf);
            end else begin
                e5 = q5.pop_front();
                if ({b_ovf, b_acc} == e5) m_pass++;
                else $display("FAIL b_result: got acc=%0d ovf=%0d, required acc=%0d ovf=%0d",
                              b_acc, b_ovf, e5[9:0], e5[10]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic send(input bit use_b, input logic [7:0] p);
        int n;
        n = 0;
        if (use_b) begin b_valid = 1'b1; b_p = p; end
        else       begin a_valid = 1'b1; a_p = p; end
        while ((use_b ? b_rdy : a_rdy) !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                $display("FAIL send_timeout: in_ready stuck low, required 1 within 50 cycles");
                $fatal(1);
            end
        end
        @(posedge clk); #1;
        if (use_b) b_valid = 1'b0;
        else       a_valid = 1'b0;
    endtask

    initial begin
        int s;
        int n;
        rst_n = 1'b0;
        a_clear = 0; a_valid = 0; a_p = 0; a_or = 0;
        b_clear = 0; b_valid = 0; b_p = 0; b_or = 1;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", a_rdy, 1);
        chk("rst_acc", a_acc, 0);

        // Partial batch, then an asynchronous reset mid-cycle discards it.
        send(0, 8'd7);
        send(0, 8'd9);
        chk("partial_cnt", a_cnt, 2);
        chk("partial_acc", a_acc, 16);
        #3 rst_n = 1'b0;
        #1;
        chk("async_acc", a_acc, 0);
        chk("async_cnt", a_cnt, 0);
        chk("async_ovalid", a_ov, 0);
        chk("async_ovf", a_ovf, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", a_rdy, 1);

        // Basic batch with out_ready held high.
        a_or = 1'b1;
        q4.push_back({1'b0, 10'd72});
        send(0, 8'd15); send(0, 8'd25); send(0, 8'd16); send(0, 8'd16);
        chk("basic_ovalid", a_ov, 1);
        chk("basic_in_ready_done", a_rdy, 0);
        chk("basic_cnt", a_cnt, 0);
        @(posedge clk); #1;
        chk("basic_back_ready", a_rdy, 1);
        chk("basic_back_ovalid", a_ov, 0);
        chk("basic_back_acc", a_acc, 0);

        // Gapped input and 5 cycles of backpressure; in_valid offered during DONE.
        a_or = 1'b0;
        q4.push_back({1'b0, 10'd900});
        for (int k = 0; k < 4; k++) begin
            send(0, 8'd225);
            if (k < 3) begin @(posedge clk); #1; end
        end
        a_valid = 1'b1; a_p = 8'd50;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {a_ov, a_rdy, a_acc}, {1'b1, 1'b0, 10'd900});
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        a_or = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_acc", a_acc, 0);
        chk("bp_handoff_ovalid", a_ov, 0);
        chk("bp_handoff_cnt", a_cnt, 0);

        // Clear beats a same-cycle product.
        send(0, 8'd3);
        send(0, 8'd5);
        a_valid = 1'b1; a_p = 8'd9; a_clear = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; a_clear = 1'b0;
        chk("clear_cnt", a_cnt, 0);
        chk("clear_acc", a_acc, 0);
        q4.push_back({1'b0, 10'd4});
        for (int k = 0; k < 4; k++) send(0, 8'd1);

        // Overflow on the 5-term instance: 5*225 = 1125.
`ifdef MAC_SATURATE_EN
        q5.push_back({1'b1, 10'd1023});
`else
        q5.push_back({1'b1, 10'd101});
`endif
        for (int k = 0; k < 5; k++) send(1, 8'd225);
        chk("ovf_flag", b_ovf, 1);

        // All 4x4 products in batches of four.
        for (int k = 0; k < 256 && !m_stop; k += 4) begin
            s = 0;
            for (int t = 0; t < 4; t++) s += ((k + t) / 16) * ((k + t) % 16);
            q4.push_back({1'b0, 10'(s)});
            for (int t = 0; t < 4; t++) send(0, 8'(((k + t) / 16) * ((k + t) % 16)));
        end

        n = 0;
        while ((q4.size() + q5.size()) != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drain", q4.size() + q5.size(), 0);

        n_pass  = n_pass + m_pass;
        n_total = n_total + m_total;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Downstream consumer of the 4x4 structural multiplier.
- Takes the 8-bit product p from the multiplier through a valid/ready handshake.
- Sums N_TERMS consecutive products into one result.
- Presents the sum with a second valid/ready handshake.
- Forms the accumulate half of the team's dot-product path. The multiplier stays combinational; all sequencing lives here.

Parameters:
PW, 8, product width; matches multiplier output p[7:0].
ACC_W, 10, accumulator/result width; 10 holds 4*225=900 without overflow.
N_TERMS, 4, products summed per result; legal range 2..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort of the current batch, active-high.
p_in  input  PW  product from multiplier (zero-extended to ACC_W before adding).
in_valid  input  1  p_in valid this cycle.
in_ready  output  1  block accepts p_in this cycle.
acc_out  output  ACC_W  accumulated result; stable while out_valid=1.
out_valid  output  1  acc_out holds a completed batch.
out_ready  input  1  downstream takes acc_out this cycle.
overflow  output  1  batch sum exceeded 2^ACC_W-1; valid alongside out_valid.
term_cnt  output  8  products accepted in current batch (0..N_TERMS-1).

Behaviour:
- Reset (rst_n=0, asynchronous): state=ACCUM, acc_out=0, term_cnt=0, out_valid=0, overflow=0. in_ready reads 1 once rst_n deasserts.
- FSM states: ACCUM, DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready at a rising edge.
  - On accept: acc_out <= acc_out + zext(p_in); term_cnt++.
  - Carry out of ACC_W sets overflow (sticky for the batch).
- ACCUM -> DONE: on the accept that makes the batch reach N_TERMS products. Same edge: term_cnt <= 0, out_valid <= 1.
- Latency: result visible the cycle after the last accepted product.
- DONE:
  - in_ready=0; in_valid is ignored and no product is consumed.
  - acc_out and overflow hold.
  - On out_valid && out_ready: acc_out <= 0, overflow <= 0, out_valid <= 0, state -> ACCUM.
  - A new product can be accepted the cycle after the handoff. There is no same-cycle pass-through.
- Backpressure: out_valid stays 1 with acc_out unchanged for any number of cycles until out_ready=1.
- in_ready depends only on state (registered), never on in_valid or out_ready combinationally.
- clear=1 (priority over all except reset), any state:
  - acc_out=0, term_cnt=0, overflow=0, out_valid=0, state=ACCUM.
  - A product offered in the same cycle is dropped and is not counted.
- Arithmetic: unsigned. The adder is ACC_W+1 bits wide; bit ACC_W is the carry.
- Overflow without saturation: acc_out wraps modulo 2^ACC_W.
- Reset mid-batch: partial sum is discarded; no out_valid pulse.

Optional Feature:
MAC_SATURATE_EN
- Defined: on carry, acc_out clamps to 2^ACC_W-1 and stays clamped for the remainder of the batch. overflow=1.
- Undefined: acc_out wraps modulo 2^ACC_W. overflow=1 is still reported.
- Handshake timing is identical in both builds.

Test Plan:
- Reset then idle: rst_n=0 pulse mid-cycle -> acc_out=0, out_valid=0, overflow=0, term_cnt=0 immediately (async); in_ready=1 after release.
- Basic batch, defaults: products 15,25,16,16, in_valid held 1, out_ready=1 -> out_valid=1 one cycle after 4th accept; acc_out=72, overflow=0; in_ready=0 in DONE; back to ACCUM next cycle.
- Gaps and backpressure: products 225 x4 with in_valid toggling 1/0, out_ready=0 for 5 cycles -> acc_out=900 held stable with out_valid=1 all 5 cycles; in_valid ignored in DONE; handoff when out_ready=1.
- Overflow, N_TERMS=5: 225 x5 -> without MAC_SATURATE_EN acc_out=101 (1125 mod 1024), overflow=1; with it acc_out=1023, overflow=1.
- Clear mid-batch: accept 3,5, then clear=1 together with in_valid=1 and p_in=9 -> term_cnt=0, acc_out=0, 9 not counted; next four products 1,1,1,1 -> acc_out=4.
- Exhaustive chain: drive p_in=i*j for all i,j in 0..15 in batches of 4 -> each acc_out equals the reference sum of its batch; error and stop on first mismatch.
